manual_drive_ctrl: RTL and testbench

MANUAL_DRIVE_CTRL -- requirements
Module: manual_drive_ctrl

---
 rtl/manual_drive_ctrl.sv | 170 +++++++++++++++++
 tb/tb_manual_drive_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/manual_drive_ctrl.sv
// Manual drive controller: filters WASD commands from the Arduino link, guards the link
// with a watchdog, and ramps speed through an OFF/STOPPED/RUN/BRAKE state machine.
module manual_drive_ctrl #(
  parameter int unsigned CMD_W          = 8,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned SPEED_W        = 8,
  parameter int unsigned SPEED_MAX      = 255,
  parameter int unsigned RAMP_DIV       = 1000,
  parameter int unsigned RAMP_STEP      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CMD_W-1:0]   cmd,
  input  logic               cmd_valid,
  input  logic               manual_on,
  output logic [8:0]         dir_onehot,
  output logic [SPEED_W-1:0] speed,
  output logic               timed_out
);

  localparam int unsigned DIR_W  = 9;
  localparam int unsigned STB_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIR_W-1:0] DIR_STOP = 9'h100;

  typedef enum logic [1:0] {S_OFF, S_STOPPED, S_RUN, S_BRAKE} state_t;

  state_t             state, state_n;
  logic [DIR_W-1:0]   candidate, accepted, active_dir, active_n, dir_n;
  logic [STB_W-1:0]   stable_cnt;
  logic [WD_W-1:0]    wd_cnt;
  logic [TICK_W-1:0]  tick_cnt;
  logic [SPEED_W-1:0] speed_n, speed_up_c, speed_dn_c;
  logic [SPEED_W:0]   speed_sum_c;
  logic [DIR_W-1:0]   decoded_c;
  logic               wd_expire_c, tick_c;

  // Command byte to one-hot direction; anything outside the table means Stop.
  function automatic logic [DIR_W-1:0] decode(input logic [CMD_W-1:0] c);
    logic [DIR_W-1:0] d;
    d = DIR_STOP;
    if ((c >> 4) == '0) begin
      case (c[3:0])
        4'h1, 4'hA: d = 9'h001;
        4'h4:       d = 9'h002;
        4'h2:       d = 9'h004;
        4'h8:       d = 9'h008;
        4'h3:       d = 9'h010;
        4'h9:       d = 9'h020;
        4'h6:       d = 9'h040;
        4'hC:       d = 9'h080;
        default:    d = DIR_STOP;
      endcase
    end
    return d;
  endfunction

  assign decoded_c   = decode(cmd);
  assign wd_expire_c = !cmd_valid && (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));
  assign tick_c      = (tick_cnt == TICK_W'(RAMP_DIV - 1));

  // Stability filter and accepted command; expiry discards the held candidate so
  // that resuming after a link loss needs a fresh stable run of samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      candidate  <= DIR_STOP;
      stable_cnt <= '0;
      accepted   <= DIR_STOP;
    end else if (wd_expire_c) begin
      candidate  <= DIR_STOP;
      stable_cnt <= '0;
      accepted   <= DIR_STOP;
    end else begin
      if (stable_cnt == STB_W'(STABLE_CYCLES)) accepted <= candidate;
      if (cmd_valid) begin
        if (decoded_c == candidate) begin
          if (stable_cnt != STB_W'(STABLE_CYCLES)) stable_cnt <= stable_cnt + STB_W'(1);
        end else begin
          candidate  <= decoded_c;
          stable_cnt <= STB_W'(1);
        end
      end
    end
  end

  // Link watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
    end else if (cmd_valid) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_expire_c) timed_out <= 1'b1;
    end
  end

  assign speed_sum_c = {1'b0, speed} + (SPEED_W + 1)'(RAMP_STEP);
  assign speed_up_c  = (speed_sum_c > (SPEED_W + 1)'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX)
                                                                  : speed_sum_c[SPEED_W-1:0];
  assign speed_dn_c  = (speed < SPEED_W'(RAMP_STEP)) ? '0 : speed - SPEED_W'(RAMP_STEP);

  // Next state, direction and speed; a state change suppresses the ramp step.
  always_comb begin
    state_n  = state;
    active_n = active_dir;
    speed_n  = speed;
    dir_n    = '0;
    if (!manual_on) begin
      state_n = S_OFF;
      speed_n = '0;
    end else begin
      case (state)
        S_OFF: state_n = S_STOPPED;
        S_STOPPED: begin
          if (accepted != DIR_STOP) begin
            state_n  = S_RUN;
            active_n = accepted;
          end
        end
        S_RUN: begin
          if (accepted != active_dir) state_n = S_BRAKE;
          else if (tick_c)            speed_n = speed_up_c;
        end
        S_BRAKE: begin
          if (accepted == active_dir) begin
            state_n = S_RUN;
          end else if (speed == '0) begin
            if (accepted == DIR_STOP) begin
              state_n = S_STOPPED;
            end else begin
              state_n  = S_RUN;
              active_n = accepted;
            end
          end else if (tick_c) begin
            speed_n = speed_dn_c;
          end
        end
        default: state_n = S_OFF;
      endcase
    end
    case (state_n)
      S_OFF:     dir_n = '0;
      S_STOPPED: dir_n = DIR_STOP;
      default:   dir_n = active_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_OFF;
      active_dir <= DIR_STOP;
      tick_cnt   <= '0;
      dir_onehot <= '0;
      speed      <= '0;
    end else begin
      state      <= state_n;
      active_dir <= active_n;
      dir_onehot <= dir_n;
      speed      <= speed_n;
      if (state_n != state || tick_c) tick_cnt <= '0;
      else                            tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Directed scenarios plus a randomized phase, each edge compared against a
// cycle-level behavioural model of the manual drive controller.
module tb_manual_drive_ctrl;

  localparam int ST   = 3;
  localparam int TO   = 20;
  localparam int RD   = 2;
  localparam int RS   = 64;
  localparam int SMAX = 255;

  localparam int M_OFF = 0, M_STOPPED = 1, M_RUN = 2, M_BRAKE = 3;
  localparam int STOP_IDX = 8;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, manual_on;
  logic [7:0] cmd;
  logic [8:0] dir_onehot;
  logic [7:0] speed;
  logic       timed_out;

  int vectors = 0;
  int miscompares = 0;

  // model state: directions are indices 0..8 (8 = Stop)
  int m_mode, m_cand, m_cnt, m_acc, m_wd, m_to, m_tick, m_act, m_speed;

  logic [7:0] codes [12] = '{8'h00, 8'h01, 8'h0A, 8'h04, 8'h02, 8'h08,
                             8'h03, 8'h09, 8'h06, 8'h0C, 8'h31, 8'h0F};

  always #5 clk = ~clk;

  manual_drive_ctrl #(
    .CMD_W(8), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO), .SPEED_W(8),
    .SPEED_MAX(SMAX), .RAMP_DIV(RD), .RAMP_STEP(RS)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .manual_on(manual_on), .dir_onehot(dir_onehot), .speed(speed),
    .timed_out(timed_out)
  );

  function automatic int dec(input logic [7:0] c);
    if (c[7:4] != 4'h0) return STOP_IDX;
    case (c[3:0])
      4'h1, 4'hA: return 0;
      4'h4: return 1;
      4'h2: return 2;
      4'h8: return 3;
      4'h3: return 4;
      4'h9: return 5;
      4'h6: return 6;
      4'hC: return 7;
      default: return STOP_IDX;
    endcase
  endfunction

  function automatic logic [8:0] exp_dir();
    logic [8:0] one;
    one = 9'd1;
    if (m_mode == M_OFF) return 9'd0;
    if (m_mode == M_STOPPED) return one << STOP_IDX;
    return one << m_act;
  endfunction

  task automatic model_edge(input logic [7:0] c, input logic v, input logic on, input logic rst);
    int o_mode, o_acc, o_cnt, o_cand, o_speed, o_tick, o_act;
    bit tick, expire;
    if (rst) begin
      m_mode = M_OFF; m_cand = STOP_IDX; m_cnt = 0; m_acc = STOP_IDX; m_wd = 0;
      m_to = 0; m_tick = 0; m_act = STOP_IDX; m_speed = 0;
      return;
    end
    o_mode = m_mode; o_acc = m_acc; o_cnt = m_cnt; o_cand = m_cand;
    o_speed = m_speed; o_tick = m_tick; o_act = m_act;
    expire = 0;
    if (v) begin
      m_wd = 0; m_to = 0;
    end else begin
      if (m_wd < TO) m_wd++;
      if (m_wd == TO) begin expire = 1; m_to = 1; end
    end
    if (expire) begin
      m_acc = STOP_IDX; m_cand = STOP_IDX; m_cnt = 0;
    end else begin
      if (o_cnt == ST) m_acc = o_cand;
      if (v) begin
        if (dec(c) == o_cand) m_cnt = (o_cnt < ST) ? o_cnt + 1 : ST;
        else begin m_cand = dec(c); m_cnt = 1; end
      end
    end
    tick = (o_tick == RD - 1);
    if (!on) begin
      m_mode = M_OFF; m_speed = 0;
    end else begin
      case (o_mode)
        M_OFF: m_mode = M_STOPPED;
        M_STOPPED: if (o_acc != STOP_IDX) begin m_mode = M_RUN; m_act = o_acc; end
        M_RUN: begin
          if (o_acc != o_act) m_mode = M_BRAKE;
          else if (tick) m_speed = (o_speed + RS > SMAX) ? SMAX : o_speed + RS;
        end
        default: begin
          if (o_acc == o_act) m_mode = M_RUN;
          else if (o_speed == 0) begin
            if (o_acc == STOP_IDX) m_mode = M_STOPPED;
            else begin m_mode = M_RUN; m_act = o_acc; end
          end else if (tick) m_speed = (o_speed < RS) ? 0 : o_speed - RS;
        end
      endcase
    end
    m_tick = (m_mode != o_mode || tick) ? 0 : o_tick + 1;
  endtask

  task automatic step(input logic [7:0] c, input logic v, input logic on, input logic rst);
    cmd = c; cmd_valid = v; manual_on = on; reset = rst;
    @(posedge clk);
    model_edge(c, v, on, rst);
    #1;
    vectors++;
    assert (dir_onehot === exp_dir()) else begin
      miscompares++;
      $error("FAIL dir_onehot: observed %h expected %h (vector %0d)", dir_onehot, exp_dir(), vectors);
    end
    assert (speed === 8'(m_speed)) else begin
      miscompares++;
      $error("FAIL speed: observed %0d expected %0d (vector %0d)", speed, m_speed, vectors);
    end
    assert (timed_out === 1'(m_to)) else begin
      miscompares++;
      $error("FAIL timed_out: observed %b expected %0d (vector %0d)", timed_out, m_to, vectors);
    end
    assert ($onehot0(dir_onehot)) else begin
      miscompares++;
      $error("FAIL onehot0: observed %h expected at most one bit (vector %0d)", dir_onehot, vectors);
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    int bound;
    // reset
    step(8'h00, 1'b1, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1, 1'b1);
    check_val("rst_dir", 16'(dir_onehot), 16'h0000);
    check_val("rst_speed", 16'(speed), 16'h0000);
    check_val("rst_to", 16'(timed_out), 16'h0000);

    // enable and idle on Stop
    repeat (6) step(8'h00, 1'b1, 1'b1, 1'b0);
    check_val("idle_dir", 16'(dir_onehot), 16'h0100);

    // filter rejection: alternating commands never settle
    for (int i = 0; i < 12; i++) step((i % 2 != 0) ? 8'h04 : 8'h01, 1'b1, 1'b1, 1'b0);
    check_val("filt_dir", 16'(dir_onehot), 16'h0100);
    check_val("filt_speed", 16'(speed), 16'h0000);

    // ramp up in Fwd
    repeat (3) step(8'h01, 1'b1, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b1, 1'b0);
    check_val("lat_e1_dir", 16'(dir_onehot), 16'h0100);
    step(8'h01, 1'b1, 1'b1, 1'b0);
    check_val("lat_e2_dir", 16'(dir_onehot), 16'h0001);
    check_val("lat_e2_speed", 16'(speed), 16'h0000);
    step(8'h01, 1'b1, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b1, 1'b0);
    check_val("ramp_64", 16'(speed), 16'd64);
    repeat (2) step(8'h01, 1'b1, 1'b1, 1'b0);
    check_val("ramp_128", 16'(speed), 16'd128);
    repeat (2) step(8'h01, 1'b1, 1'b1, 1'b0);
    check_val("ramp_192", 16'(speed), 16'd192);
    repeat (2) step(8'h01, 1'b1, 1'b1, 1'b0);
    check_val("ramp_255", 16'(speed), 16'd255);
    repeat (4) step(8'h01, 1'b1, 1'b1, 1'b0);
    check_val("ramp_hold", 16'(speed), 16'd255);

    // reversal to Back
    repeat (13) step(8'h04, 1'b1, 1'b1, 1'b0);
    check_val("rev_speed0", 16'(speed), 16'h0000);
    check_val("rev_dir_hold", 16'(dir_onehot), 16'h0001);
    repeat (3) step(8'h04, 1'b1, 1'b1, 1'b0);
    check_val("rev_dir_back", 16'(dir_onehot), 16'h0002);

    // watchdog
    repeat (19) step(8'h04, 1'b0, 1'b1, 1'b0);
    check_val("wd_not_yet", 16'(timed_out), 16'h0000);
    step(8'h04, 1'b0, 1'b1, 1'b0);
    check_val("wd_fired", 16'(timed_out), 16'h0001);
    repeat (12) step(8'h04, 1'b0, 1'b1, 1'b0);
    check_val("wd_dir", 16'(dir_onehot), 16'h0100);
    check_val("wd_speed", 16'(speed), 16'h0000);
    step(8'h00, 1'b1, 1'b1, 1'b0);
    check_val("wd_clear", 16'(timed_out), 16'h0000);

    // undefined command brakes to STOPPED
    repeat (12) step(8'h01, 1'b1, 1'b1, 1'b0);
    check_val("undef_pre_dir", 16'(dir_onehot), 16'h0001);
    repeat (20) step(8'h31, 1'b1, 1'b1, 1'b0);
    check_val("undef_dir", 16'(dir_onehot), 16'h0100);
    check_val("undef_speed", 16'(speed), 16'h0000);

    // disable mid-ramp
    repeat (8) step(8'h01, 1'b1, 1'b1, 1'b0);
    check_val("dis_pre_speed", 16'(speed), 16'd64);
    step(8'h01, 1'b1, 1'b0, 1'b0);
    check_val("dis_dir", 16'(dir_onehot), 16'h0000);
    check_val("dis_speed", 16'(speed), 16'h0000);

    // reset at speed 128
    bound = 0;
    while (m_speed != 128 && bound < 30) begin
      step(8'h01, 1'b1, 1'b1, 1'b0);
      bound++;
    end
    if (m_speed != 128) begin
      miscompares++;
      $error("FAIL reach_128: observed model speed %0d expected 128 within 30 cycles", m_speed);
    end
    step(8'h01, 1'b1, 1'b1, 1'b1);
    check_val("rst128_dir", 16'(dir_onehot), 16'h0000);
    check_val("rst128_speed", 16'(speed), 16'h0000);
    check_val("rst128_to", 16'(timed_out), 16'h0000);

    // randomized phase
    for (int blk = 0; blk < 300; blk++) begin
      int idx, len, r;
      bit on, rst;
      idx = $urandom_range(0, 11);
      r   = $urandom_range(0, 19);
      len = (r == 0) ? 25 : $urandom_range(1, 10);
      on  = ($urandom_range(0, 30) != 0);
      rst = ($urandom_range(0, 60) == 0);
      for (int i = 0; i < len; i++) begin
        int k;
        bit v;
        k = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 11) : idx;
        v = (r == 0) ? 1'b0 : ($urandom_range(0, 9) != 0);
        step(codes[k], v, on, rst && (i == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
